fir_seq_ctrl: RTL and testbench

- Sequencer for the FIR_Filter datapath (WL-bit samples/coefficients; coefficients shift in one per clock while x_en=1, samples shift in while x_en=0).
- Holds a host-writable coefficient bank, replays it into the filter on command, then streams samples through a valid/ready interface.
- Drains the filter with zeros on stop and tags outputs with m_valid.
- Sits between the host/config bus plus sample source and the FIR_Filter instance.

---
 rtl/fir_seq_ctrl_if.sv | 33 +++
 rtl/fir_seq_ctrl.sv | 99 +++++++++
 tb/tb_fir_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: config, command, sample stream and filter-side signals of the FIR sequencer
interface fir_seq_ctrl_if #(
    parameter int WL = 8,
    parameter int AW = 5
);
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [WL-1:0] cfg_data;
    logic          load_req;
    logic          run_en;
    logic          s_valid;
    logic [WL-1:0] s_data;
    logic          s_ready;
    logic          fir_x_en;
    logic [WL-1:0] fir_h;
    logic [WL-1:0] fir_x;
    logic [WL-1:0] fir_y;
    logic          m_valid;
    logic [WL-1:0] m_data;
    logic          busy;
    logic          loaded;
    logic          cfg_err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, load_req, run_en, s_valid, s_data, fir_y,
        output s_ready, fir_x_en, fir_h, fir_x, m_valid, m_data, busy, loaded, cfg_err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, load_req, run_en, s_valid, s_data, fir_y,
        input  s_ready, fir_x_en, fir_h, fir_x, m_valid, m_data, busy, loaded, cfg_err
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: loads a coefficient bank into an FIR filter, streams samples through it and tags outputs
module fir_seq_ctrl #(
    parameter int WL      = 8,
    parameter int L       = 3,
    parameter int AW      = 5,
    parameter int FIR_LAT = 1
) (
    input logic           clk,
    input logic           reset,
    fir_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(L + 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, FLUSH} state_t;

    state_t        state;
    logic [WL-1:0] bank [L];
    logic [CW-1:0] cnt;
    logic [FIR_LAT:0] vpipe;
    logic          wr_ok;
    logic [WL-1:0] h0;

    assign wr_ok    = bus.cfg_we && (bus.cfg_addr < AW'(L));
    // a write to entry 0 on the same edge as load_req must reach the filter first
    assign h0       = (wr_ok && bus.cfg_addr == '0) ? bus.cfg_data : bank[0];
    assign bus.busy = (state == LOAD) || (state == RUN) || (state == FLUSH);

    // sequencer: bank writes, coefficient replay, sample streaming, drain and valid tagging
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            vpipe        <= '0;
            for (int i = 0; i < L; i++) bank[i] <= '0;
            bus.fir_x_en <= 1'b0;
            bus.fir_h    <= '0;
            bus.fir_x    <= '0;
            bus.s_ready  <= 1'b0;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= '0;
            bus.loaded   <= 1'b0;
            bus.cfg_err  <= 1'b0;
        end else begin
            vpipe       <= {vpipe[FIR_LAT-1:0], 1'b0};
            bus.m_valid <= vpipe[FIR_LAT];
            bus.m_data  <= vpipe[FIR_LAT] ? bus.fir_y : '0;
            bus.fir_x   <= '0;
            case (state)
                IDLE, READY: begin
                    if (wr_ok) bank[bus.cfg_addr] <= bus.cfg_data;
                    if (bus.load_req) begin
                        state        <= LOAD;
                        cnt          <= '0;
                        bus.loaded   <= 1'b0;
                        bus.cfg_err  <= 1'b0;
                        bus.fir_x_en <= 1'b1;
                        bus.fir_h    <= h0;
                    end else if (state == READY && wr_ok) begin
                        state      <= IDLE;
                        bus.loaded <= 1'b0;
                    end else if (state == READY && bus.run_en) begin
                        state       <= RUN;
                        bus.s_ready <= 1'b1;
                    end
                    if (bus.cfg_we && !wr_ok) bus.cfg_err <= 1'b1;
                end
                LOAD: begin
                    if (bus.cfg_we) bus.cfg_err <= 1'b1;
                    if (cnt == CW'(L - 1)) begin
                        state        <= READY;
                        bus.fir_x_en <= 1'b0;
                        bus.fir_h    <= '0;
                        bus.loaded   <= 1'b1;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        bus.fir_h <= bank[cnt + CW'(1)];
                    end
                end
                RUN: begin
                    if (bus.cfg_we) bus.cfg_err <= 1'b1;
                    if (!bus.run_en) begin
                        state       <= FLUSH;
                        bus.s_ready <= 1'b0;
                        cnt         <= '0;
                    end else if (bus.s_valid && bus.s_ready) begin
                        bus.fir_x <= bus.s_data;
                        vpipe[0]  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (bus.cfg_we) bus.cfg_err <= 1'b1;
                    if (cnt != CW'(L - 1)) cnt <= cnt + CW'(1);
                    if (cnt >= CW'(L - 2) && vpipe == '0) state <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: randomized scoreboard bench for fir_seq_ctrl with a behavioural FIR filter stand-in
module tb_fir_seq_ctrl;
    localparam int WL = 8, L = 3, AW = 5, FIR_LAT = 1;

    typedef struct {
        logic [WL-1:0] d;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0, bad = 0, cyc = 0;
    exp_t sb[$];
    exp_t e;
    int rbank [L];
    int lbank [L];
    int hist[$];
    logic [WL-1:0] dir [4] = '{8'h0D, 8'hE6, 8'h26, 8'hCD};
    logic [WL-1:0] hreg [L];
    logic [WL-1:0] xreg [L];
    logic [31:0] acc;

    fir_seq_ctrl_if #(.WL(WL), .AW(AW)) bus();

    fir_seq_ctrl #(.WL(WL), .L(L), .AW(AW), .FIR_LAT(FIR_LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // filter stand-in: coefficients shift while x_en=1, samples otherwise; y is combinational on the delay line
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                hreg[k] <= '0;
                xreg[k] <= '0;
            end
        end else if (bus.fir_x_en) begin
            for (int k = L - 1; k > 0; k--) hreg[k] <= hreg[k-1];
            hreg[0] <= bus.fir_h;
        end else begin
            for (int k = L - 1; k > 0; k--) xreg[k] <= xreg[k-1];
            xreg[0] <= bus.fir_x;
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < L; k++) acc = acc + 32'(hreg[k]) * 32'(xreg[k]);
        bus.fir_y = acc[WL-1:0];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    // monitor: every output cycle is either an expected sample at its expected cycle or an idle zero
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.m_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL m_valid_extra: got m_data=%0h expected no output (cycle %0d)", bus.m_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", 32'(bus.m_data), 32'(e.d));
                    chk("m_valid_cycle", cyc, e.c);
                end
            end else begin
                chk("m_data_idle", 32'(bus.m_data), 0);
            end
        end
    end

    function automatic logic [WL-1:0] ref_y();
        int s = 0;
        for (int k = 0; k < L && k < hist.size(); k++) s += lbank[L-1-k] * hist[k];
        return WL'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = WL'(d);
        if (a < L) rbank[a] = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_load(input bit wr, input int a, input int d);
        bus.load_req = 1'b1;
        if (wr) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(a);
            bus.cfg_data = WL'(d);
            if (a < L) rbank[a] = d;
        end
        step();
        bus.load_req = 1'b0;
        bus.cfg_we   = 1'b0;
        lbank = rbank;
        for (int i = 0; i < L; i++) begin
            chk("load_x_en", 32'(bus.fir_x_en), 1);
            chk("load_h", 32'(bus.fir_h), lbank[i]);
            chk("load_x", 32'(bus.fir_x), 0);
            chk("load_busy", 32'(bus.busy), 1);
            if (i == 0) chk("load_err_clear", 32'(bus.cfg_err), 0);
            step();
        end
        chk("load_end_x_en", 32'(bus.fir_x_en), 0);
        chk("load_end_h", 32'(bus.fir_h), 0);
        chk("load_end_loaded", 32'(bus.loaded), 1);
        chk("load_end_busy", 32'(bus.busy), 0);
    endtask

    task automatic run_stream(input int n, input bit directed, input bit inject);
        logic v;
        logic [WL-1:0] d;
        bus.run_en = 1'b1;
        for (int t = 0; t < 20 && !bus.s_ready; t++) step();
        chk("run_start_ready", 32'(bus.s_ready), 1);
        hist.delete();
        for (int i = 0; i < n; i++) begin
            v = directed ? !(i == 4 || i == 5) : ($urandom_range(0, 3) != 0);
            d = (directed && i < 4) ? dir[i] : WL'($urandom);
            bus.s_valid = v;
            bus.s_data  = d;
            if (inject && i == 2) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = '0;
                bus.cfg_data = 8'hFF;
            end
            hist.push_front(v ? int'(d) : 0);
            if (v) sb.push_back('{ref_y(), cyc + 2 + FIR_LAT});
            step();
            bus.cfg_we = 1'b0;
            chk("fir_x", 32'(bus.fir_x), v ? 32'(d) : 0);
            if (inject && i == 2) chk("run_write_err", 32'(bus.cfg_err), 1);
        end
        bus.run_en  = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = WL'($urandom);
        step();
        bus.s_valid = 1'b0;
        chk("stop_ready", 32'(bus.s_ready), 0);
        chk("stop_busy", 32'(bus.busy), 1);
        chk("stop_x", 32'(bus.fir_x), 0);
        for (int t = 0; t < 40 && bus.busy; t++) step();
        chk("flush_busy", 32'(bus.busy), 0);
        chk("flush_loaded", 32'(bus.loaded), 1);
        chk("flush_x", 32'(bus.fir_x), 0);
        repeat (FIR_LAT + 3) step();
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string n);
        chk({n, "_x_en"}, 32'(bus.fir_x_en), 0);
        chk({n, "_h"}, 32'(bus.fir_h), 0);
        chk({n, "_x"}, 32'(bus.fir_x), 0);
        chk({n, "_ready"}, 32'(bus.s_ready), 0);
        chk({n, "_m_valid"}, 32'(bus.m_valid), 0);
        chk({n, "_m_data"}, 32'(bus.m_data), 0);
        chk({n, "_busy"}, 32'(bus.busy), 0);
        chk({n, "_loaded"}, 32'(bus.loaded), 0);
        chk({n, "_err"}, 32'(bus.cfg_err), 0);
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.load_req = 0; bus.run_en = 0; bus.s_valid = 0; bus.s_data = '0;
        for (int i = 0; i < L; i++) rbank[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b0;
        step();
        bus.run_en = 1'b1;
        repeat (3) step();
        chk("idle_run_ready", 32'(bus.s_ready), 0);
        chk("idle_run_busy", 32'(bus.busy), 0);
        bus.run_en = 1'b0;
        cfg_write(0, 8'hEB);
        cfg_write(1, 8'h33);
        cfg_write(2, 8'h1A);
        chk("cfg_ok_err", 32'(bus.cfg_err), 0);
        do_load(0, 0, 0);
        repeat (3) step();
        run_stream(12, 1, 0);
        cfg_write(5, 8'h77);
        chk("bad_addr_err", 32'(bus.cfg_err), 1);
        chk("bad_addr_loaded", 32'(bus.loaded), 1);
        run_stream(10, 0, 1);
        chk("err_sticky", 32'(bus.cfg_err), 1);
        do_load(0, 0, 0);
        for (int i = 0; i < L; i++) begin
            cfg_write(i, int'($urandom_range(0, 255)));
            if (i == 0) chk("stale_loaded", 32'(bus.loaded), 0);
        end
        do_load(0, 0, 0);
        repeat (3) step();
        run_stream(int'($urandom_range(12, 20)), 0, 0);
        bus.load_req = 1'b1;
        step();
        bus.load_req = 1'b0;
        step();
        #2 reset = 1'b1;
        #1 chk_zero_outputs("mid_load_reset");
        for (int i = 0; i < L; i++) rbank[i] = 0;
        step();
        step();
        reset = 1'b0;
        step();
        do_load(0, 0, 0);
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        do_load(1, 0, 8'h5A);
        repeat (3) step();
        run_stream(8, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
